nps_outmem_capture: RTL

- Sink stage directly downstream of the NPS input-memory source. It consumes that source's valid/data stream and finish flag.
- Captures up to DATANUM result words into an internal array and reports completion to the top-level sequencer.
- Provides a synchronous read-back port so the host or bench can dump captured results after a run.

---
 rtl/nps_pkg.sv | 15 +
 rtl/nps_outmem_ram.sv | 36 +++
 rtl/nps_outmem_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/nps_pkg.sv
// Shared NPS definitions: capture FSM states and default sizes common to the
// source and sink stages.
package nps_pkg;

    localparam int DATANUM_DEF = 256;
    localparam int DW_DEF      = 16;
    localparam int CSUM_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/nps_outmem_ram.sv
// Simple dual-port result array: one write port, one registered read-first
// read port. Addresses at or beyond DEPTH read back as zero.
module nps_outmem_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // Sampling mem with a non-blocking read gives old data on a same-address write.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rd_data <= '0;
        end else if ({1'b0, rd_adr} < (AW+1)'(DEPTH)) begin
            rd_data <= mem[rd_adr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/nps_outmem_capture.sv
// NPS output-memory sink: captures up to DATANUM words from the source stage
// and flags completion. Optional checksum port enabled by OUTMEM_CHECKSUM_EN.
module nps_outmem_capture
    import nps_pkg::*;
#(
    parameter int DATANUM = DATANUM_DEF,
    parameter int DW      = DW_DEF,
    parameter int ADR_W   = $clog2(DATANUM)
) (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              start,
    input  logic              vi,
    input  logic [DW-1:0]     di,
    input  logic              fi,
    input  logic [ADR_W-1:0]  rd_adr,
    output logic [DW-1:0]     rd_data,
    output logic [ADR_W:0]    count,
    output logic              busy,
    output logic              fo,
`ifdef OUTMEM_CHECKSUM_EN
    output logic [CSUM_W-1:0] csum,
`endif
    output logic              ovf
);

    state_t           state_q;
    state_t           state_d;
    logic [ADR_W-1:0] wr_adr;
    logic             wr_en;
    logic             last_word;

    // A start in the same cycle always wins over the incoming beat.
    assign wr_en     = (state_q == CAPTURE) && vi && !start;
    assign last_word = (wr_adr == ADR_W'(DATANUM - 1));

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (start)                 state_d = CAPTURE;
                else if (vi && last_word)  state_d = DONE;
                else if (fi)               state_d = DONE;
            end
            DONE: begin
                if (start) state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CAPTURE);
        fo   = (state_q == DONE);
    end

    // wr_adr parks on the last index so it never wraps inside a run.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            wr_adr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (start) begin
            wr_adr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                if (!last_word) wr_adr <= wr_adr + 1'b1;
                if (count != (ADR_W+1)'(DATANUM)) count <= count + 1'b1;
            end
            if (vi && (state_q != CAPTURE)) ovf <= 1'b1;
        end
    end

`ifdef OUTMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (wr_en) begin
            csum <= csum + CSUM_W'(di);
        end
    end
`endif

    nps_outmem_ram #(
        .DEPTH (DATANUM),
        .DW    (DW),
        .AW    (ADR_W)
    ) u_ram (
        .clk     (clk),
        .reset_x (reset_x),
        .wr_en   (wr_en),
        .wr_adr  (wr_adr),
        .wr_data (di),
        .rd_adr  (rd_adr),
        .rd_data (rd_data)
    );

endmodule
